regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_pkg.sv | 12 +
 rtl/regfile_sb_scoreboard.sv | 63 ++++++
 rtl/regfile_sb.sv | 79 +++++++
 tb/tb_regfile_sb.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared defaults and the address-width helper for the scoreboarded register file.
package regfile_sb_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Index width needed to address n registers (n is a power of two >= 2).
    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: reservation handshake, writeback clear, flush and pending count.
module regfile_sb_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = addr_width(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             rd_wren,
    input  logic [AW-1:0]    rd_addr,
    input  logic             rsv_valid,
    input  logic [AW-1:0]    rsv_addr,
    output logic             rsv_ready,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busy_cnt
);

    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_nxt_s;
    logic [AW:0]      busy_cnt_r;
    logic [AW:0]      cnt_nxt_s;
    logic             wb_en_s;
    logic             set_s;
    logic             clr_s;
    logic             inc_s;

    // Handshake decode and next busy state; a same-register reservation wins over writeback.
    always_comb begin
        wb_en_s    = rd_wren && (rd_addr != {AW{1'b0}});
        rsv_ready  = !flush && ((rsv_addr == {AW{1'b0}}) || !busy_r[rsv_addr] ||
                                (rd_wren && (rd_addr == rsv_addr)));
        set_s      = rsv_valid && rsv_ready && (rsv_addr != {AW{1'b0}});
        clr_s      = wb_en_s && busy_r[rd_addr] && !(set_s && (rsv_addr == rd_addr));
        inc_s      = set_s && !busy_r[rsv_addr];
        busy_nxt_s = busy_r;
        busy_nxt_s[rd_addr]  = wb_en_s ? 1'b0 : busy_nxt_s[rd_addr];
        busy_nxt_s[rsv_addr] = set_s   ? 1'b1 : busy_nxt_s[rsv_addr];
        cnt_nxt_s  = busy_cnt_r + {{AW{1'b0}}, inc_s} - {{AW{1'b0}}, clr_s};
        if (flush) begin
            busy_nxt_s = {NREGS{1'b0}};
            cnt_nxt_s  = {(AW+1){1'b0}};
        end else begin
            cnt_nxt_s  = cnt_nxt_s;
        end
    end

    // Busy vector and population count state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r     <= {NREGS{1'b0}};
            busy_cnt_r <= {(AW+1){1'b0}};
        end else begin
            busy_r     <= busy_nxt_s;
            busy_cnt_r <= cnt_nxt_s;
        end
    end

    assign busy     = busy_r;
    assign busy_cnt = busy_cnt_r;

endmodule

// File: rtl/regfile_sb.sv
// Register file with busy-bit scoreboard and NRD combinational read ports.
// Optional same-cycle writeback forwarding on reads: define REGFILE_SB_BYPASS_EN.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    localparam int AW   = addr_width(NREGS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NRD*AW-1:0] i_rs_addr,
    output logic [NRD*XLEN-1:0] o_rs_data,
    output logic [NRD-1:0]    o_rs_busy,
    input  logic [AW-1:0]     i_rd_addr,
    input  logic [XLEN-1:0]   i_rd_data,
    input  logic              i_rd_wren,
    input  logic              i_rsv_valid,
    input  logic [AW-1:0]     i_rsv_addr,
    output logic              o_rsv_ready,
    input  logic              i_flush,
    output logic [AW:0]       o_busy_cnt
);

    logic [XLEN-1:0]  regs_r [NREGS];
    logic [NREGS-1:0] busy_s;
    logic             wb_en_s;

    assign wb_en_s = i_rd_wren && (i_rd_addr != {AW{1'b0}});

    regfile_sb_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk       (i_clk),
        .rst_n     (i_rst),
        .flush     (i_flush),
        .rd_wren   (i_rd_wren),
        .rd_addr   (i_rd_addr),
        .rsv_valid (i_rsv_valid),
        .rsv_addr  (i_rsv_addr),
        .rsv_ready (o_rsv_ready),
        .busy      (busy_s),
        .busy_cnt  (o_busy_cnt)
    );

    // Register storage; x0 is never written so it stays at its reset value of zero.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wb_en_s) begin
            regs_r[i_rd_addr] <= i_rd_data;
        end
    end

    // Read muxes; forwarding is suppressed during reset so reads stay zero.
    always_comb begin
        o_rs_data = {(NRD*XLEN){1'b0}};
        o_rs_busy = {NRD{1'b0}};
        for (int k = 0; k < NRD; k++) begin
`ifdef REGFILE_SB_BYPASS_EN
            if (i_rst && wb_en_s && (i_rd_addr == i_rs_addr[k*AW +: AW])) begin
                o_rs_data[k*XLEN +: XLEN] = i_rd_data;
                o_rs_busy[k]              = 1'b0;
            end else begin
                o_rs_data[k*XLEN +: XLEN] = regs_r[i_rs_addr[k*AW +: AW]];
                o_rs_busy[k]              = busy_s[i_rs_addr[k*AW +: AW]];
            end
`else
            o_rs_data[k*XLEN +: XLEN] = regs_r[i_rs_addr[k*AW +: AW]];
            o_rs_busy[k]              = busy_s[i_rs_addr[k*AW +: AW]];
`endif
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, randomized model compare, corner sequences.
module tb_regfile_sb;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rs_addr;
    logic [63:0] rs_data;
    logic [1:0]  rs_busy;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_wren;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        rsv_ready;
    logic        flush;
    logic [5:0]  busy_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    regfile_sb dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_rs_addr   (rs_addr),
        .o_rs_data   (rs_data),
        .o_rs_busy   (rs_busy),
        .i_rd_addr   (rd_addr),
        .i_rd_data   (rd_data),
        .i_rd_wren   (rd_wren),
        .i_rsv_valid (rsv_valid),
        .i_rsv_addr  (rsv_addr),
        .o_rsv_ready (rsv_ready),
        .i_flush     (flush),
        .o_busy_cnt  (busy_cnt)
    );

    typedef struct {
        logic        wren;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rv;
        logic [4:0]  ra;
        logic        fl;
        logic [4:0]  rs0;
        logic        e_ready;
        logic [31:0] e_data;
        logic        e_busy;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wren, input logic [4:0] wa, input logic [31:0] wd,
                         input logic rv, input logic [4:0] ra, input logic fl,
                         input logic [4:0] r0, input logic [4:0] r1);
        rd_wren = wren; rd_addr = wa; rd_data = wd;
        rsv_valid = rv; rsv_addr = ra; flush = fl;
        rs_addr = {r1, r0};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Reference read of one port from the specification's rules.
    function automatic logic [32:0] model_read(input logic [4:0] a);
        if (BYP && rd_wren && rd_addr == a && a != 5'd0)
            return {1'b0, rd_data};
        return {m_busy[a], (a == 5'd0) ? 32'd0 : m_regs[a]};
    endfunction

    initial begin
        logic        e_rdy;
        logic [32:0] r0, r1;
        int          pop;

        vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 32'h0,        1'b0, 6'd0};
        vecs[1]  = '{1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 6'd0};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 32'h0,        1'b0, 6'd0};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 32'h0,        1'b0, 6'd1};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd7, 1'b0, 32'h0,        1'b1, 6'd1};
        vecs[5]  = '{1'b1, 5'd7, 32'h55,       1'b0, 5'd7, 1'b0, 5'd0, 1'b1, 32'h0,        1'b0, 6'd0};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 32'h55,       1'b0, 6'd0};
        vecs[7]  = '{1'b1, 5'd3, 32'hA5,       1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 32'h0,        1'b0, 6'd1};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd3, 1'b0, 5'd3, 1'b0, 32'hA5,       1'b1, 6'd1};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 32'h0,        1'b0, 6'd2};
        vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 32'h0,        1'b0, 6'd3};
        vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 32'h0,        1'b0, 6'd4};
        vecs[12] = '{1'b1, 5'd2, 32'h77,       1'b1, 5'd9, 1'b1, 5'd4, 1'b0, 32'h0,        1'b1, 6'd0};
        vecs[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd9, 1'b0, 5'd9, 1'b1, 32'h0,        1'b0, 6'd0};
        vecs[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 32'h77,       1'b0, 6'd0};

        // Reset state
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd7);
        #3;
        chk("reset_cnt", busy_cnt, 6'd0);
        chk("reset_rs_data", rs_data, 64'd0);
        chk("reset_rs_busy", rs_busy, 2'd0);
        do_reset();

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].wren, vecs[i].wa, vecs[i].wd, vecs[i].rv, vecs[i].ra,
                  vecs[i].fl, vecs[i].rs0, 5'd0);
            #1;
            chk($sformatf("vec%0d_ready", i), rsv_ready, vecs[i].e_ready);
            chk($sformatf("vec%0d_data", i), rs_data[31:0], vecs[i].e_data);
            chk($sformatf("vec%0d_busy", i), rs_busy[0], vecs[i].e_busy);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_cnt", i), busy_cnt, vecs[i].e_cnt);
            @(negedge clk);
        end

        // Randomized compare against the reference model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 15) == 0), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)));
            #1;
            e_rdy = !flush && (rsv_addr == 5'd0 || !m_busy[rsv_addr] ||
                               (rd_wren && rd_addr == rsv_addr));
            r0 = model_read(rs_addr[4:0]);
            r1 = model_read(rs_addr[9:5]);
            chk("rnd_ready", rsv_ready, e_rdy);
            chk("rnd_rs0", {rs_busy[0], rs_data[31:0]}, r0);
            chk("rnd_rs1", {rs_busy[1], rs_data[63:32]}, r1);
            @(posedge clk);
            if (rd_wren && rd_addr != 5'd0) begin
                m_regs[rd_addr] = rd_data;
                m_busy[rd_addr] = 1'b0;
            end
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else if (rsv_valid && e_rdy && rsv_addr != 5'd0) begin
                m_busy[rsv_addr] = 1'b1;
            end
            pop = 0;
            for (int i = 0; i < 32; i++) pop += int'(m_busy[i]);
            #1;
            chk("rnd_cnt", busy_cnt, 6'(pop));
            @(negedge clk);
        end

        // Writeback forwarding visibility on x8
        drive(1'b1, 5'd8, 32'h11, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        @(negedge clk);
        drive(1'b1, 5'd8, 32'h99, 1'b0, 5'd0, 1'b0, 5'd0, 5'd8);
        #1;
        chk("fwd_same_data", rs_data[63:32], BYP ? 32'h99 : 32'h11);
        chk("fwd_same_busy", rs_busy[1], 1'b0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd8);
        #1;
        chk("fwd_next_data", rs_data[63:32], 32'h99);

        // Mid-cycle asynchronous reset with x10 reserved
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 1'b0, 5'd10, 5'd8);
        #1;
        chk("x10_rsv_ready", rsv_ready, 1'b1);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd10, 5'd8);
        #1;
        chk("x10_busy", rs_busy[0], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", busy_cnt, 6'd0);
        chk("arst_rs_data", rs_data, 64'd0);
        chk("arst_rs_busy", rs_busy, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 1'b0, 5'd10, 5'd0);
        #1;
        chk("post_rst_ready", rsv_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("post_rst_cnt", busy_cnt, 6'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
